// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the slave (the adder) returns the registered result.
interface ripple_carry_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;
    logic             out_valid;

    modport master (
        output in_valid, A, B, Cin,
        input  Sum, Cout, Overflow, out_valid
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output Sum, Cout, Overflow, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-in and signed overflow flag.
// The carry chain is an explicit array of 1-bit full-adder cells, LSB to MSB,
// followed by a single output register stage with a valid qualifier.

// One full-adder cell of the chain.
module ripple_carry_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    // Propagate term shared by the sum and carry paths.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ripple_carry_adder_if.slave   bus
);
    // c[i] is the carry into cell i; c[0] is Cin, c[WIDTH] is the carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic [WIDTH-1:0] s_w;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             vld_q;

    assign a_w  = bus.A;
    assign b_w  = bus.B;
    assign c[0] = bus.Cin;

    // Array of cells: cell i takes c[i] and hands c[i+1] to cell i+1.
    ripple_carry_adder_fa u_fa [WIDTH-1:0] (
        .a  (a_w),
        .b  (b_w),
        .ci (c[WIDTH-1:0]),
        .s  (s_w),
        .co (c[WIDTH:1])
    );

    // Output register: reset wins, in_valid captures, otherwise hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= s_w;
                cout_q <= c[WIDTH];
                // Signed overflow: carry into the MSB differs from carry out of it.
                // For WIDTH = 1 the carry into the MSB is Cin itself (c[0]).
                ovf_q  <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end

    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.Overflow  = ovf_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed, table-driven and sweep checks of the registered ripple-carry adder
// at WIDTH = 4, plus random operands at WIDTH = 16.
module tb_ripple_carry_adder;
    logic clk;
    logic rst;

    ripple_carry_adder_if #(.WIDTH(4))  bus4 ();
    ripple_carry_adder_if #(.WIDTH(16)) bus16 ();

    ripple_carry_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    ripple_carry_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
        logic       vld;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result of a WIDTH-bit add computed with plain integer arithmetic.
    function automatic logic [16:0] ref_sum(input int w, input longint a, input longint b, input int cin);
        longint t;
        t = a + b + cin;
        return 17'(t & ((64'd1 << (w + 1)) - 1));
    endfunction

    // Signed overflow: the true signed sum falls outside the WIDTH-bit signed range.
    function automatic logic ref_ovf(input int w, input longint a, input longint b, input int cin);
        longint sa, sb, t, lim;
        lim = 64'd1 << (w - 1);
        sa  = (a >= lim) ? a - 2 * lim : a;
        sb  = (b >= lim) ? b - 2 * lim : b;
        t   = sa + sb + cin;
        return (t > lim - 1) || (t < -lim);
    endfunction

    initial begin
        tests = 0;
        fails = 0;

        //           rst   iv    a        b        cin   sum      cout  ovf   vld
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 4'b0111, 4'b0001, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'b0111, 4'b1010, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 4'b0111, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'b0101, 4'b0011, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'b1000, 4'b0110, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1};

        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.A         = '0;
        bus4.B         = '0;
        bus4.Cin       = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.A        = '0;
        bus16.B        = '0;
        bus16.Cin      = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: each row is applied for one edge, then checked.
        for (int i = 0; i < 14; i++) begin
            rst           = vecs[i].rst;
            bus4.in_valid = vecs[i].iv;
            bus4.A        = vecs[i].a;
            bus4.B        = vecs[i].b;
            bus4.Cin      = vecs[i].cin;
            @(posedge clk);
            #1;
            check($sformatf("row%0d sum", i),  64'(bus4.Sum),       64'(vecs[i].sum));
            check($sformatf("row%0d cout", i), 64'(bus4.Cout),      64'(vecs[i].cout));
            check($sformatf("row%0d ovf", i),  64'(bus4.Overflow),  64'(vecs[i].ovf));
            check($sformatf("row%0d vld", i),  64'(bus4.out_valid), 64'(vecs[i].vld));
            if (i == 0) begin
                check("w16 reset sum", 64'(bus16.Sum),       64'd0);
                check("w16 reset vld", 64'(bus16.out_valid), 64'd0);
            end
        end

        // Operands wiggling between edges must not reach the registers.
        bus4.in_valid = 1'b1;
        bus4.A = 4'b0001; bus4.B = 4'b0010; bus4.Cin = 1'b0;
        #2 bus4.A = 4'b1111;
        #2 bus4.A = 4'b0001;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.A = 4'b1110; bus4.B = 4'b1101; bus4.Cin = 1'b1;
        #3 bus4.A = 4'b0000;
        check("glitch sum", 64'(bus4.Sum), 64'd3);
        check("glitch vld", 64'(bus4.out_valid), 64'd1);
        @(posedge clk);
        #1;
        check("glitch hold", 64'(bus4.Sum), 64'd3);

        // Exhaustive WIDTH=4 sweep, back-to-back one per cycle.
        bus4.in_valid = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    bus4.A   = 4'(a);
                    bus4.B   = 4'(b);
                    bus4.Cin = 1'(ci);
                    @(posedge clk);
                    #1;
                    check($sformatf("sw %0d+%0d+%0d", a, b, ci),
                          {59'd0, bus4.Cout, bus4.Sum}, 64'(ref_sum(4, a, b, ci)));
                    check($sformatf("sw ovf %0d+%0d+%0d", a, b, ci),
                          64'(bus4.Overflow), 64'(ref_ovf(4, a, b, ci)));
                    check("sw vld", 64'(bus4.out_valid), 64'd1);
                end
            end
        end
        bus4.in_valid = 1'b0;

        // Random WIDTH=16 operands, with a few forced full-carry cases first.
        bus16.in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (k == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
            if (k == 1) begin ra = 16'h0000; rb = 16'h0000; rc = 1'b1; end
            if (k == 2) begin ra = 16'h7FFF; rb = 16'h0000; rc = 1'b1; end
            bus16.A   = ra;
            bus16.B   = rb;
            bus16.Cin = rc;
            @(posedge clk);
            #1;
            check($sformatf("w16 %h+%h+%0d", ra, rb, rc),
                  {47'd0, bus16.Cout, bus16.Sum}, 64'(ref_sum(16, longint'(ra), longint'(rb), int'(rc))));
            check($sformatf("w16 ovf %h+%h+%0d", ra, rb, rc),
                  64'(bus16.Overflow), 64'(ref_ovf(16, longint'(ra), longint'(rb), int'(rc))));
            check("w16 vld", 64'(bus16.out_valid), 64'd1);
        end
        bus16.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("w16 vld drop", 64'(bus16.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
